// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative restoring divider for the HI/LO write port.
//   Produces one quotient bit per cycle. EX holds start_i until ready_o.
//   Result is {HI = remainder, LO = quotient}.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   signed_div_i    1 = DIV (two's complement), 0 = DIVU
//   opdata1_i       dividend (latched only when leaving IDLE)
//   opdata2_i       divisor  (latched only when leaving IDLE)
//   start_i         request, held high until ready_o seen
//   annul_i         flush; cancels a pending or running divide
//   result_o        {remainder, quotient}, zero unless ready_o
//   ready_o         result valid
// ---------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]   dvs_q, dvs_d;     // |divisor|
   logic               negq_q, negq_d;   // negate quotient at the end
   logic               negr_q, negr_d;   // negate remainder at the end
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;

   logic [WIDTH:0]     partial, diff;
   logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
   logic               a_neg, b_neg;

   always_comb begin
      a_neg   = signed_div_i & opdata1_i[WIDTH-1];
      b_neg   = signed_div_i & opdata2_i[WIDTH-1];
      abs_a   = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
      abs_b   = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
      // Shift the next dividend bit into the remainder, then trial-subtract.
      // The extra top bit of diff is the borrow: set means "restore".
      partial = {rem_q, quo_q[WIDTH-1]};
      diff    = partial - {1'b0, dvs_q};
      // Fixup is plain mod-2^WIDTH negation, so MIN / -1 wraps back to MIN.
      quo_fix = negq_q ? (~quo_q + 1'b1) : quo_q;
      rem_fix = negr_q ? (~rem_q + 1'b1) : rem_q;

      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;

      case (state_q)
         IDLE: begin
            ready_d  = 1'b0;
            result_d = '0;
            if (start_i && !annul_i) begin
               cnt_d = '0;
               rem_d = '0;
               if (opdata2_i == '0) begin
                  // Zeroed working regs make the END load produce a zero result.
                  quo_d   = '0;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = BYZERO;
               end else begin
                  quo_d   = abs_a;
                  dvs_d   = abs_b;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  state_d = ON;
               end
            end
         end
         BYZERO: state_d = END;
         ON: begin
            if (annul_i) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               rem_d = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_d = END;
            end
         end
         END: begin
            // Outputs are registered, so ready_o rises one edge after entry.
            if (start_i) begin
               ready_d  = 1'b1;
               result_d = {rem_fix, quo_fix};
            end else begin
               ready_d  = 1'b0;
               result_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
